// File: rtl/imm_extend_pipe.sv
// Immediate-extension unit: SEXT/ZEXT/LUI/BR results queued in a 2-entry output buffer.
// Optional IMM_EXT_STATS_EN adds a saturating 16-bit accepted-transfer counter on stat_count.
module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_neg
`ifdef IMM_EXT_STATS_EN
   ,
   output logic [15:0]      stat_count
`endif
);

   generate
      if (IN_W < 2) begin : g_bad_in_w
         $error("imm_extend_pipe: IN_W must be at least 2");
      end
      if (OUT_W < IN_W + 2) begin : g_bad_out_w
         $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
      end
   endgenerate

   typedef enum logic [1:0] {
      MODE_SEXT = 2'd0,
      MODE_ZEXT = 2'd1,
      MODE_LUI  = 2'd2,
      MODE_BR   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      CNT_EMPTY = 2'd0,
      CNT_ONE   = 2'd1,
      CNT_FULL  = 2'd2
   } cnt_e;

   // BR reuses the sign-extended value: the two bits shifted out are copies of the sign.
   function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] imm,
                                                   input mode_e mode);
      logic signed [OUT_W-1:0] sx;
      logic        [OUT_W-1:0] res;
      sx = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
      case (mode)
         MODE_SEXT: res = sx;
         MODE_ZEXT: res = {{(OUT_W-IN_W){1'b0}}, imm};
         MODE_LUI:  res = {imm, {(OUT_W-IN_W){1'b0}}};
         MODE_BR:   res = sx <<< 2;
         default:   res = sx;
      endcase
      return res;
   endfunction

`ifdef IMM_EXT_STATS_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
`endif

   cnt_e             cnt_q, cnt_d;
   logic             wptr_q, wptr_d;
   logic             rptr_q, rptr_d;
   logic [OUT_W-1:0] buf_q [2];
   logic             push, pop;

   assign in_ready  = ~rst & (cnt_q != CNT_FULL);
   assign out_valid = ~rst & (cnt_q != CNT_EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      cnt_d  = cnt_q;
      wptr_d = push ? ~wptr_q : wptr_q;
      rptr_d = pop  ? ~rptr_q : rptr_q;
      case (cnt_q)
         CNT_EMPTY: if (push) cnt_d = CNT_ONE;
         CNT_ONE: begin
            if (push && !pop)      cnt_d = CNT_FULL;
            else if (pop && !push) cnt_d = CNT_EMPTY;
         end
         CNT_FULL:  if (pop) cnt_d = CNT_ONE;
         default:   cnt_d = CNT_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= CNT_EMPTY;
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Extension stage -> buffer register boundary
   always_ff @(posedge clk) begin
      if (push) buf_q[wptr_q] <= extend_imm(in_data, mode_e'(in_mode));
   end

   assign out_data = out_valid ? buf_q[rptr_q] : '0;
   assign out_neg  = out_data[OUT_W-1];

`ifdef IMM_EXT_STATS_EN
   logic [15:0] stat_q, stat_d;

   assign stat_d = push ? sat_inc16(stat_q) : stat_q;

   always_ff @(posedge clk) begin
      if (rst) stat_q <= 16'd0;
      else     stat_q <= stat_d;
   end

   assign stat_count = stat_q;
`endif

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension unit for the datapath's decode/execute boundary. It accepts an IN_W-bit immediate plus a 2-bit mode over a valid/ready handshake. It produces a registered OUT_W-bit operand: sign-extended, zero-extended, upper-placed (LUI), or sign-extended and word-shifted (branch offset). A 2-entry output buffer decouples backpressure from the immediate source.

## Interface

Parameters:
- IN_W, 16, immediate input width; must be ≥ 2.
- OUT_W, 32, extended output width; must be ≥ IN_W+2 (elaboration error otherwise).

Ports:
- clk  in  1  rising-edge clock; all state changes on this edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  source presents a transfer.
- in_ready  out  1  unit can accept a transfer; `~rst & (count != 2)`, derived only from registered state.
- in_data  in  IN_W  raw immediate.
- in_mode  in  2  0=SEXT, 1=ZEXT, 2=LUI, 3=BR.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  sink accepts the head entry.
- out_data  out  OUT_W  extended result of the head entry; 0 whenever out_valid=0.
- out_neg  out  1  MSB of out_data; 0 whenever out_valid=0.
- stat_count  out  16  accepted-transfer counter; present only with IMM_EXT_STATS_EN.

## Operation

- Push when in_valid & in_ready. Pop when out_valid & out_ready.
- The result is computed combinationally at push and written into the buffer. The buffer stores results, not raw inputs.
- Mode arithmetic, with s = in_data[IN_W-1]:
  - SEXT: {(OUT_W-IN_W){s}, in_data}.
  - ZEXT: {(OUT_W-IN_W){0}, in_data}.
  - LUI: {in_data, (OUT_W-IN_W){0}}.
  - BR: {(OUT_W-IN_W-2){s}, in_data, 2'b00}. No overflow is possible given the parameter constraint.
- Buffer: 2 entries, FIFO order, with a write pointer, a read pointer (1 bit each, wrapping 1→0) and a count 0..2.
- Count state transitions:
  - EMPTY(0): push → ONE.
  - ONE(1): push only → FULL; pop only → EMPTY; push+pop → ONE (head advances, new entry queued).
  - FULL(2): in_ready=0, so no push; pop → ONE.
- Simultaneous push and pop when count=0 is impossible, because out_valid=0.
- in_valid while in_ready=0: no effect. The source must hold in_data and in_mode stable until accepted.
- out_valid and out_data, once asserted, stay stable until popped.

## Timing

- Reset (rst high at an edge): count, pointers and stat_count go to 0; out_valid=0, out_data=0, out_neg=0. in_ready=0 while rst is high and 1 on the first cycle after deassertion.
- Reset mid-operation discards all buffered entries. No pop handshake completes in the reset cycle.
- Latency: push at edge N → out_valid=1 from cycle N+1 when the buffer was empty.
- Throughput: 1 transfer/cycle with out_ready held high.
- Backpressure: with out_ready=0 the unit absorbs 2 transfers, then in_ready=0.
- From FULL: a pop at edge M → in_ready=1 in cycle M+1. There is no combinational out_ready→in_ready path.
- No combinational path from in_* to out_*.

## Configuration

- IMM_EXT_STATS_EN defined:
  - Adds the stat_count port and a 16-bit counter.
  - The counter increments by 1 on every push and saturates at 0xFFFF (no wrap).
  - Reset clears it to 0.
- IMM_EXT_STATS_EN undefined: no port and no counter logic. All other behaviour is identical.

## Test plan

Defaults IN_W=16, OUT_W=32.

- Sign vs zero: push 0x8000 SEXT, then 0x8000 ZEXT, out_ready=1 → out_data 0xFFFF8000 (out_neg=1), then 0x00008000 (out_neg=0), on consecutive cycles, each one cycle after its push.
- LUI/BR: push 0x1234 LUI, 0xFFFF BR, 0x0001 BR → 0x12340000, 0xFFFFFFFC, 0x00000004, in order.
- Backpressure: out_ready=0; offer A=0x0001, B=0x0002, C=0x0003 (SEXT) → A and B accepted, in_ready=0 with C held. Raise out_ready → outputs 0x00000001, 0x00000002, 0x00000003 in order; in_ready returns the cycle after the first pop.
- Streaming push+pop at count=1: continuous in_valid/out_ready for 8 words → 8 outputs, no bubbles after the first, count stays 1.
- Reset mid-operation: fill to count=2, assert rst one cycle → out_valid=0, out_data=0, in_ready=0 during reset and 1 the following cycle; buffered words never appear.
- Stats (IMM_EXT_STATS_EN): 3 pushes → stat_count=3. Preload to 0xFFFE via 0xFFFE pushes, then 2 more → holds 0xFFFF. rst → 0.
